// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// the default reset PC.
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    IFU_S_REQ   = 2'd0,
    IFU_S_WAIT  = 2'd1,
    IFU_S_OUT   = 2'd2,
    IFU_S_FENCE = 2'd3
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h3000_0000;

endpackage

// File: rtl/ifu_perf_cnt.sv
// Free-running wrap-around event counters for the fetch unit
// (built only when IFU_PERF_EN is defined).
module ifu_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fetch_inc) fetch_cnt <= fetch_cnt + 32'd1;
      if (stall_inc) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one I$ fetch at a time, hands
// instructions to decode, squashes in-flight fetches on redirect and sequences
// fence.i invalidation. Optional perf counters under IFU_PERF_EN.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        fence_i_req_i,
  output logic        icache_arvalid_o,
  input  logic        icache_arready_i,
  output logic [31:0] icache_araddr_o,
  input  logic        icache_rvalid_i,
  output logic        icache_rready_o,
  input  logic [31:0] icache_rdata_i,
  output logic        fence_i_o,
  input  logic        icache_flush_done_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_stall_cnt_o
`endif
);

  ifu_state_e  state;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        drop;
  logic        fence_pend;
  logic        req_hs, rsp_hs, inst_hs, redir_fence;

  assign req_hs      = icache_arvalid_o & icache_arready_i;
  assign rsp_hs      = icache_rvalid_i & icache_rready_o;
  assign inst_hs     = inst_valid_o & inst_ready_i;
  assign redir_fence = redirect_valid_i & fence_i_req_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IFU_S_REQ;
      pc         <= RESET_PC;
      inst       <= '0;
      drop       <= 1'b0;
      fence_pend <= 1'b0;
    end else begin
      if (redir_fence && state != IFU_S_FENCE) fence_pend <= 1'b1;
      case (state)
        IFU_S_REQ: begin
          if (redirect_valid_i) pc <= redirect_pc_i;
          if (req_hs) begin
            state <= IFU_S_WAIT;
            drop  <= redirect_valid_i;
          end else if (redir_fence) begin
            state <= IFU_S_FENCE;
          end
        end
        IFU_S_WAIT: begin
          if (redirect_valid_i) pc <= redirect_pc_i;
          if (rsp_hs) begin
            drop <= 1'b0;
            // A redirect landing with the response squashes it just like an earlier one
            if (drop || redirect_valid_i)
              state <= (fence_pend || redir_fence) ? IFU_S_FENCE : IFU_S_REQ;
            else begin
              inst  <= icache_rdata_i;
              state <= IFU_S_OUT;
            end
          end else if (redirect_valid_i) begin
            drop <= 1'b1;
          end
        end
        IFU_S_OUT: begin
          if (redirect_valid_i) begin
            pc    <= redirect_pc_i;
            state <= redir_fence ? IFU_S_FENCE : IFU_S_REQ;
          end else if (inst_hs) begin
            pc    <= pc + 32'd4;
            state <= IFU_S_REQ;
          end
        end
        IFU_S_FENCE: begin
          if (redirect_valid_i) pc <= redirect_pc_i;
          if (icache_flush_done_i) begin
            fence_pend <= 1'b0;
            state      <= IFU_S_REQ;
          end
        end
        default: state <= IFU_S_REQ;
      endcase
    end
  end

  assign icache_arvalid_o = (state == IFU_S_REQ);
  assign icache_araddr_o  = pc;
  assign icache_rready_o  = (state == IFU_S_WAIT);
  assign fence_i_o        = (state == IFU_S_FENCE);
  assign inst_valid_o     = (state == IFU_S_OUT);
  assign inst_o           = inst;
  assign pc_o             = pc;

`ifdef IFU_PERF_EN
  logic stall_inc;
  assign stall_inc = (state == IFU_S_REQ) || (state == IFU_S_WAIT);

  ifu_perf_cnt u_perf (
    .clk       (clk),
    .rst       (rst),
    .fetch_inc (inst_hs),
    .stall_inc (stall_inc),
    .fetch_cnt (perf_fetch_cnt_o),
    .stall_cnt (perf_stall_cnt_o)
  );
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed test-plan sequences with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_ifu_fetch;

  localparam logic [31:0] RPC = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fence_i_req = 1'b0;
  logic        icache_arvalid;
  logic        icache_arready = 1'b0;
  logic [31:0] icache_araddr;
  logic        icache_rvalid = 1'b0;
  logic        icache_rready;
  logic [31:0] icache_rdata = '0;
  logic        fence_i;
  logic        icache_flush_done = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk                 (clk),
    .rst                 (rst),
    .redirect_valid_i    (redirect_valid),
    .redirect_pc_i       (redirect_pc),
    .fence_i_req_i       (fence_i_req),
    .icache_arvalid_o    (icache_arvalid),
    .icache_arready_i    (icache_arready),
    .icache_araddr_o     (icache_araddr),
    .icache_rvalid_i     (icache_rvalid),
    .icache_rready_o     (icache_rready),
    .icache_rdata_i      (icache_rdata),
    .fence_i_o           (fence_i),
    .icache_flush_done_i (icache_flush_done),
    .inst_valid_o        (inst_valid),
    .inst_ready_i        (inst_ready),
    .inst_o              (inst),
    .pc_o                (pc)
`ifdef IFU_PERF_EN
    ,
    .perf_fetch_cnt_o    (perf_fetch_cnt),
    .perf_stall_cnt_o    (perf_stall_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Transaction-level view: what fetch is permitted, what is in flight,
  // whether that fetch is already squashed, what is waiting for decode.
  logic [31:0] m_pc, m_dpc, m_dinst;
  bit          m_req, m_fl, m_stale, m_fafter, m_dlv, m_fence;
  int unsigned m_fetch, m_stall;

  bit          ic_pend = 1'b0;
  int          ic_due = 0;
  logic [31:0] ic_data = '0;
  int          lat_max = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a - RPC) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_dpc = '0; m_dinst = '0;
    m_req = 1'b1; m_fl = 1'b0; m_stale = 1'b0; m_fafter = 1'b0;
    m_dlv = 1'b0; m_fence = 1'b0;
    m_fetch = 0; m_stall = 0;
  endtask

  task automatic model_step(input bit rv, input logic [31:0] rpc, input bit rf,
                            input bit arr, input bit ird, input bit rvl);
    if (m_req || m_fl) m_stall++;
    if (m_fence) begin
      m_fence = 1'b0; m_req = 1'b1;
      if (rv) m_pc = rpc;
    end else if (m_req) begin
      if (arr) begin
        m_req = 1'b0; m_fl = 1'b1; m_stale = rv; m_fafter = rv && rf;
        if (rv) m_pc = rpc;
      end else if (rv) begin
        m_pc = rpc;
        if (rf) begin m_req = 1'b0; m_fence = 1'b1; end
      end
    end else if (m_fl) begin
      if (rvl) begin
        m_fl = 1'b0;
        if (m_stale || rv) begin
          if (rv) m_pc = rpc;
          if (m_fafter || (rv && rf)) m_fence = 1'b1; else m_req = 1'b1;
          m_stale = 1'b0; m_fafter = 1'b0;
        end else begin
          m_dlv = 1'b1; m_dpc = m_pc; m_dinst = word_at(m_pc);
        end
      end else if (rv) begin
        m_stale = 1'b1; m_pc = rpc;
        if (rf) m_fafter = 1'b1;
      end
    end else if (m_dlv) begin
      if (ird) m_fetch++;
      if (rv) begin
        m_dlv = 1'b0; m_pc = rpc;
        if (rf) m_fence = 1'b1; else m_req = 1'b1;
      end else if (ird) begin
        m_dlv = 1'b0; m_pc = m_pc + 32'd4; m_req = 1'b1;
      end
    end
  endtask

  task automatic compare();
    chk("arvalid", {31'b0, icache_arvalid}, {31'b0, m_req});
    if (m_req) chk("araddr", icache_araddr, m_pc);
    chk("rready", {31'b0, icache_rready}, {31'b0, m_fl});
    chk("fence_i", {31'b0, fence_i}, {31'b0, m_fence});
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_dlv});
    if (m_dlv) begin
      chk("pc_o", pc, m_dpc);
      chk("inst_o", inst, m_dinst);
    end
`ifdef IFU_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, m_fetch);
    chk("perf_stall", perf_stall_cnt, m_stall);
`endif
  endtask

  // One clock: drive inputs, let the I$ and the model react, check after the edge.
  task automatic cycle(input bit rv, input logic [31:0] rpc, input bit rf,
                       input bit arr, input bit ird);
    redirect_valid    = rv;
    redirect_pc       = rpc;
    fence_i_req       = rf;
    icache_arready    = arr;
    inst_ready        = ird;
    icache_rvalid     = ic_pend && (cyc >= ic_due);
    icache_rdata      = icache_rvalid ? ic_data : 32'hDEAD_BEEF;
    icache_flush_done = fence_i;
    model_step(rv, rpc, rf, arr, ird, icache_rvalid);
    if (icache_rvalid && icache_rready) ic_pend = 1'b0;
    if (icache_arvalid && arr) begin
      ic_pend = 1'b1;
      ic_due  = cyc + 2 + int'($urandom_range(lat_max, 0));
      ic_data = word_at(icache_araddr);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; fence_i_req = 1'b0;
    icache_arready = 1'b0; icache_rvalid = 1'b0; icache_rdata = '0;
    icache_flush_done = 1'b0; inst_ready = 1'b0;
    ic_pend = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    compare();
    chk("rst_arvalid", {31'b0, icache_arvalid}, 32'd1);
    chk("rst_araddr", icache_araddr, 32'h3000_0000);
    chk("rst_rready", {31'b0, icache_rready}, 32'd0);
    chk("rst_fence_i", {31'b0, fence_i}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst_o", inst, 32'd0);
    chk("rst_pc_o", pc, 32'h3000_0000);
`ifdef IFU_PERF_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
`endif
  endtask

  initial begin
    bit          rv, rf, arr, ird;
    logic [31:0] rpc;

    lat_max = 0;
    do_reset(3);

    // first fetch: handshake t, rvalid t+2, decode-valid t+3
    cycle(0, 0, 0, 1, 0);
    chk("wait_rready", {31'b0, icache_rready}, 32'd1);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("first_valid", {31'b0, inst_valid}, 32'd1);
    chk("first_pc", pc, 32'h3000_0000);
    chk("first_inst", inst, 32'h0000_0013);

    // back-to-back hits: one instruction every 4 cycles
    repeat (4) cycle(0, 0, 0, 1, 1);
    chk("seq1_valid", {31'b0, inst_valid}, 32'd1);
    chk("seq1_pc", pc, 32'h3000_0004);
    chk("seq1_inst", inst, 32'h0000_0017);
    repeat (4) cycle(0, 0, 0, 1, 1);
    chk("seq2_valid", {31'b0, inst_valid}, 32'd1);
    chk("seq2_pc", pc, 32'h3000_0008);

    // redirect together with decode handshake: redirect target wins over pc+4
    cycle(1, 32'h3000_0200, 0, 0, 1);
    chk("redir_out_arvalid", {31'b0, icache_arvalid}, 32'd1);
    chk("redir_out_addr", icache_araddr, 32'h3000_0200);

    // redirect while waiting: response dropped, refetch at the new target
    cycle(0, 0, 0, 1, 0);
    cycle(1, 32'h3000_0100, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("drop_no_valid", {31'b0, inst_valid}, 32'd0);
    chk("drop_refetch", icache_araddr, 32'h3000_0100);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("drop_deliver_pc", pc, 32'h3000_0100);
    chk("drop_deliver_inst", inst, 32'h0000_0113);

    // fence.i from S_OUT: one-cycle pulse then fetch at the fence target
    cycle(1, 32'h3000_0010, 1, 0, 0);
    chk("fence_pulse", {31'b0, fence_i}, 32'd1);
    chk("fence_no_fetch", {31'b0, icache_arvalid}, 32'd0);
    cycle(0, 0, 0, 0, 0);
    chk("fence_low", {31'b0, fence_i}, 32'd0);
    chk("fence_refetch", icache_araddr, 32'h3000_0010);

    // PC wrap
    cycle(1, 32'hFFFF_FFFC, 0, 0, 0);
    chk("wrap_addr", icache_araddr, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0, 1);
    chk("wrap_next", icache_araddr, 32'h0000_0000);
`ifdef IFU_PERF_EN
    chk("perf_fetch_lit", perf_fetch_cnt, 32'd4);
`endif

    // randomized traffic with variable I$ latency and one mid-run reset
    lat_max = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset(2);
      rv  = ($urandom_range(7, 0) == 0);
      rf  = ($urandom_range(3, 0) == 0);
      arr = ($urandom_range(3, 0) != 0);
      ird = ($urandom_range(2, 0) != 0);
      if ($urandom_range(3, 0) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000C);
      else                           rpc = $urandom & 32'hFFFF_FFFC;
      cycle(rv, rpc, rf, arr, ird);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
